// File: rtl/risc_pkg.sv
// risc_pkg: definitions shared by the RISC core front end.
//   - 5-bit opcode constants (NOP..LSR, values 0..21)
//   - position of the opcode field inside a 17-bit instruction
//   - fetch FSM state encoding
//   - is_ctrl_flow(): 1 for opcodes that redirect or may redirect the PC
package risc_pkg;

  // Opcode field position inside the instruction word.
  localparam int OPC_MSB = 16;
  localparam int OPC_LSB = 12;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OPC_NOP = 5'd0;
  localparam logic [OPC_W-1:0] OPC_LDI = 5'd1;
  localparam logic [OPC_W-1:0] OPC_JML = 5'd2;
  localparam logic [OPC_W-1:0] OPC_JMP = 5'd3;
  localparam logic [OPC_W-1:0] OPC_LD  = 5'd4;
  localparam logic [OPC_W-1:0] OPC_ST  = 5'd5;
  localparam logic [OPC_W-1:0] OPC_MOV = 5'd6;
  localparam logic [OPC_W-1:0] OPC_JMR = 5'd7;
  localparam logic [OPC_W-1:0] OPC_ADD = 5'd8;
  localparam logic [OPC_W-1:0] OPC_SUB = 5'd9;
  localparam logic [OPC_W-1:0] OPC_AND = 5'd10;
  localparam logic [OPC_W-1:0] OPC_BZ  = 5'd11;
  localparam logic [OPC_W-1:0] OPC_OR  = 5'd12;
  localparam logic [OPC_W-1:0] OPC_XOR = 5'd13;
  localparam logic [OPC_W-1:0] OPC_NOT = 5'd14;
  localparam logic [OPC_W-1:0] OPC_CMP = 5'd15;
  localparam logic [OPC_W-1:0] OPC_INC = 5'd16;
  localparam logic [OPC_W-1:0] OPC_OUT = 5'd17;
  localparam logic [OPC_W-1:0] OPC_IN  = 5'd18;
  localparam logic [OPC_W-1:0] OPC_BNZ = 5'd19;
  localparam logic [OPC_W-1:0] OPC_LSL = 5'd20;
  localparam logic [OPC_W-1:0] OPC_LSR = 5'd21;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    WAIT_BR = 2'd2
  } fetch_state_t;

  // Undefined opcodes (22..31) are deliberately treated as sequential.
  function automatic logic is_ctrl_flow(input logic [OPC_W-1:0] opcode);
    logic r;
    case (opcode)
      OPC_JML, OPC_JMP, OPC_JMR, OPC_BZ, OPC_BNZ: r = 1'b1;
      default:                                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// fetch_predecode: combinational control-flow detector.
//   opcode  in  5  opcode field of the instruction being fetched
//   is_ctrl out 1  1 when the opcode is JML, JMP, JMR, BZ or BNZ
// Also reused by hazard logic, so it stays a standalone module.
module fetch_predecode
  import risc_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic             is_ctrl
);

  always_comb begin
    is_ctrl = is_ctrl_flow(opcode);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller.
// Owns the program counter, addresses a combinational program memory,
// captures each instruction into a one-entry instruction register (IR) and
// holds fetch after any control-flow instruction until execute resolves it.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   en             in   run enable; 0 stops new fetches
//   pm_addr        out  program memory address (always equals pc)
//   pm_data        in   instruction returned by program memory
//   ir_valid       out  IR holds a valid instruction
//   ir_data        out  IR contents
//   ir_pc          out  address ir_data was fetched from
//   ir_ready       in   decode accepts ir_data this cycle
//   resolve_valid  in   execute resolved the outstanding control flow
//   resolve_taken  in   1 = redirect to resolve_target, 0 = fall through
//   resolve_target in   redirect address
//   stall          out  1 while waiting for resolution
//   dbg_state      out  current FSM state, for observation only
//
// Handshake: an IR entry transfers to decode on every rising edge where
// ir_valid && ir_ready are both high. While ir_valid is high and ir_ready is
// low, ir_data/ir_pc are held unchanged. A new instruction may be written in
// the same cycle the old one is accepted, giving one instruction per cycle.
module fetch_sequencer
  import risc_pkg::*;
#(
  parameter int              AW       = 8,
  parameter int              IW       = 17,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [AW-1:0] pm_addr,
  input  logic [IW-1:0] pm_data,
  output logic          ir_valid,
  output logic [IW-1:0] ir_data,
  output logic [AW-1:0] ir_pc,
  input  logic          ir_ready,
  input  logic          resolve_valid,
  input  logic          resolve_taken,
  input  logic [AW-1:0] resolve_target,
  output logic          stall,
  output fetch_state_t  dbg_state
);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          ir_valid_q, ir_valid_d;
  logic [IW-1:0] ir_data_q, ir_data_d;
  logic [AW-1:0] ir_pc_q, ir_pc_d;

  logic is_ctrl;
  logic free;
  logic load;

  fetch_predecode u_predecode (
    .opcode  (pm_data[OPC_MSB:OPC_LSB]),
    .is_ctrl (is_ctrl)
  );

  // The IR can take a new word if it is empty or is being drained this cycle.
  assign free = !ir_valid_q || ir_ready;
  assign load = (state_q == RUN) && en && free;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      ir_valid_q <= 1'b0;
      ir_data_q  <= '0;
      ir_pc_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      ir_valid_q <= ir_valid_d;
      ir_data_q  <= ir_data_d;
      ir_pc_q    <= ir_pc_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en)                state_d = IDLE;
        else if (load && is_ctrl) state_d = WAIT_BR;
      end
      WAIT_BR: begin
        // en=0 does not abandon the wait; it only picks where we land.
        if (resolve_valid) state_d = en ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // PC and IR update.
  always_comb begin
    pc_d       = pc_q;
    ir_valid_d = ir_valid_q;
    ir_data_d  = ir_data_q;
    ir_pc_d    = ir_pc_q;

    if (load) begin
      ir_data_d  = pm_data;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
      pc_d       = pc_q + AW'(1);
    end else if (ir_valid_q && ir_ready) begin
      ir_valid_d = 1'b0;
    end

    // pc already points past the control-flow instruction, so a not-taken
    // resolution needs no PC change. Loads never happen in WAIT_BR.
    if ((state_q == WAIT_BR) && resolve_valid && resolve_taken) begin
      pc_d = resolve_target;
    end
  end

  assign pm_addr   = pc_q;
  assign ir_valid  = ir_valid_q;
  assign ir_data   = ir_data_q;
  assign ir_pc     = ir_pc_q;
  assign stall     = (state_q == WAIT_BR);
  assign dbg_state = state_q;

endmodule
